// File: rtl/pwm_multi_breather.sv
// Multi-channel LED PWM engine: shared period counter, per-channel off/static/breathe/on
// modes, with settings double-buffered so they only change at period boundaries.
module pwm_multi_breather #(
  parameter  int NUM_CH       = 26,
  parameter  int WIDTH        = 8,
  parameter  int STEP_PERIODS = 4,
  localparam int CHW          = $clog2(NUM_CH)
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              wr_en,
  input  logic [CHW-1:0]    wr_ch,
  input  logic [1:0]        wr_mode,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_end,
  output logic              step_tick
);

  localparam int SCW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [SCW-1:0] STEP_LAST = SCW'(STEP_PERIODS - 1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_ON      = 2'b11
  } mode_e;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [SCW-1:0]   step_cnt_q, step_cnt_d;
  logic             wrap, step;

  mode_e            shadow_mode_q [NUM_CH];
  mode_e            shadow_mode_d [NUM_CH];
  logic [WIDTH-1:0] shadow_duty_q [NUM_CH];
  logic [WIDTH-1:0] shadow_duty_d [NUM_CH];
  mode_e            act_mode_q    [NUM_CH];
  mode_e            act_mode_d    [NUM_CH];
  logic [WIDTH-1:0] act_duty_q    [NUM_CH];
  logic [WIDTH-1:0] act_duty_d    [NUM_CH];
  logic [WIDTH-1:0] level_q       [NUM_CH];
  logic [WIDTH-1:0] level_d       [NUM_CH];
  logic [NUM_CH-1:0] dir_down_q, dir_down_d;

  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              period_end_q, period_end_d;
  logic              step_tick_q, step_tick_d;

  always_comb begin
    cnt_d         = cnt_q + 1'b1;
    wrap          = &cnt_q;
    step          = 1'b0;
    step_cnt_d    = step_cnt_q;
    shadow_mode_d = shadow_mode_q;
    shadow_duty_d = shadow_duty_q;
    act_mode_d    = act_mode_q;
    act_duty_d    = act_duty_q;
    level_d       = level_q;
    dir_down_d    = dir_down_q;
    pwm_d         = '0;

    if (wrap) begin
      if (step_cnt_q == STEP_LAST) begin
        step       = 1'b1;
        step_cnt_d = '0;
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end
    period_end_d = wrap;
    step_tick_d  = step;

    for (int i = 0; i < NUM_CH; i++) begin
      // Out-of-range channel indices match no channel, so they are dropped here.
      if (wr_en && (wr_ch == CHW'(i))) begin
        shadow_mode_d[i] = mode_e'(wr_mode);
        shadow_duty_d[i] = wr_data;
      end

      // Commit reads the pre-write shadow, so a write on the wrap cycle waits a period.
      if (wrap) begin
        act_mode_d[i] = shadow_mode_q[i];
        case (shadow_mode_q[i])
          MODE_STATIC: act_duty_d[i] = shadow_duty_q[i];
          MODE_BREATHE: begin
            if (act_mode_q[i] != MODE_BREATHE) begin
              level_d[i]    = shadow_duty_q[i];
              dir_down_d[i] = 1'b0;
            end else if (step) begin
              // Endpoints reverse direction and move one step back: no repeated max/0.
              if (!dir_down_q[i]) begin
                if (&level_q[i]) begin
                  level_d[i]    = level_q[i] - 1'b1;
                  dir_down_d[i] = 1'b1;
                end else begin
                  level_d[i] = level_q[i] + 1'b1;
                end
              end else begin
                if (level_q[i] == '0) begin
                  level_d[i]    = level_q[i] + 1'b1;
                  dir_down_d[i] = 1'b0;
                end else begin
                  level_d[i] = level_q[i] - 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end

      case (act_mode_q[i])
        MODE_OFF:     pwm_d[i] = 1'b0;
        MODE_STATIC:  pwm_d[i] = (cnt_q < act_duty_q[i]);
        MODE_BREATHE: pwm_d[i] = (cnt_q < level_q[i]);
        MODE_ON:      pwm_d[i] = 1'b1;
        default:      pwm_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      cnt_q        <= '0;
      step_cnt_q   <= '0;
      dir_down_q   <= '0;
      pwm_q        <= '0;
      period_end_q <= 1'b0;
      step_tick_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_mode_q[i] <= MODE_OFF;
        shadow_duty_q[i] <= '0;
        act_mode_q[i]    <= MODE_OFF;
        act_duty_q[i]    <= '0;
        level_q[i]       <= '0;
      end
    end else begin
      cnt_q         <= cnt_d;
      step_cnt_q    <= step_cnt_d;
      dir_down_q    <= dir_down_d;
      pwm_q         <= pwm_d;
      period_end_q  <= period_end_d;
      step_tick_q   <= step_tick_d;
      shadow_mode_q <= shadow_mode_d;
      shadow_duty_q <= shadow_duty_d;
      act_mode_q    <= act_mode_d;
      act_duty_q    <= act_duty_d;
      level_q       <= level_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign period_end = period_end_q;
  assign step_tick  = step_tick_q;

endmodule

// File: doc/pwm_multi_breather.md
Name: pwm_multi_breather

Overview:
- Parameterised multi-channel PWM engine driving board LEDs.
- One free-running period counter is shared by every channel.
- Each channel runs in one of four modes: off, static duty, triangular "breathing" ramp with programmable phase, or constant on.
- Channel settings are written through a single-cycle write port. Changes are double-buffered and take effect only at period boundaries, so outputs never glitch mid-period.

Parameters:
- NUM_CH, 26, number of PWM channels (one per LED).
- WIDTH, 8, counter, duty and level width; PWM period is 2^WIDTH clocks.
- STEP_PERIODS, 4, number of PWM periods per breathing step (>=1).
- CHW, $clog2(NUM_CH), width of the channel index (derived; not overridden).

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- RESET_N  in  1  synchronous reset, active-low.
- wr_en  in  1  write strobe, one cycle per write.
- wr_ch  in  CHW  target channel index.
- wr_mode  in  2  mode: 00 off, 01 static, 10 breathe, 11 on.
- wr_data  in  WIDTH  static: duty; breathe: starting level (phase); ignored for off/on.
- pwm_out  out  NUM_CH  registered PWM outputs, bit i = channel i.
- period_end  out  1  one-cycle pulse, registered, asserted the cycle after cnt = 2^WIDTH-1.
- step_tick  out  1  one-cycle pulse coincident with period_end on breathing-step periods.

Behaviour:
- One clock (CLOCK_50); reset is synchronous and active-low (RESET_N sampled on the CLOCK_50 rising edge).
- Reset state:
  - cnt = 0 and step counter = 0.
  - All shadow and active modes = off; shadow and active duty = 0.
  - All levels = 0; all directions = up.
  - pwm_out = 0, period_end = 0, step_tick = 0.
- Reset mid-period abandons the period immediately; counting restarts from 0 on the first cycle after RESET_N rises.
- cnt: WIDTH-bit, increments every cycle and wraps from 2^WIDTH-1 to 0. "Wrap" means the cycle in which cnt = 2^WIDTH-1.
- Step counter: counts wraps from 0 to STEP_PERIODS-1. A step occurs on a wrap when the step counter = STEP_PERIODS-1; the counter then returns to 0.
- Write port:
  - When wr_en=1 and wr_ch < NUM_CH, shadow_mode[wr_ch] <= wr_mode and shadow_duty[wr_ch] <= wr_data.
  - Writes with wr_ch >= NUM_CH are ignored with no side effects.
  - No backpressure; a write is accepted every cycle.
- Commit at wrap: for every channel, active_mode <= shadow_mode. Then, per the new mode:
  - static: active duty <= shadow_duty.
  - breathe, entered from any other mode: level <= shadow_duty, direction <= up.
  - breathe, already active: level is kept.
  - off / on: duty is unused.
- Write coincident with wrap: the commit uses the shadow value held before that cycle. The new write lands in shadow and commits at the next wrap. There is no bypass.
- Breathing step (at wrap, for channels whose active mode is already breathe):
  - up and level < max: level+1.
  - up and level = max (2^WIDTH-1): level = max-1, direction = down.
  - down and level > 0: level-1.
  - down and level = 0: level = 1, direction = up.
  - Resulting sequence: 0,1,...,max,max-1,...,0,1,... with no repeated endpoints.
- Output, with a 1-cycle registered latency from cnt:
  - off: pwm_out[i] = 0.
  - on: pwm_out[i] = 1.
  - static: pwm_out[i] = (cnt < duty).
  - breathe: pwm_out[i] = (cnt < level).
  - Duty 0 gives 0% on. Duty max gives (2^WIDTH-1)/2^WIDTH on; mode on is the only 100% case.
- Comparisons use the active values that apply to the current period. New active values first influence the compare in the cycle after the wrap (cnt = 0), so the first output bit under them appears one cycle later.
- Unsigned arithmetic throughout; no saturation beyond the rules above.

Test Plan:
- Static duty (WIDTH=4): after reset, write ch0 static duty=5 -> from the first full period after the next wrap, pwm_out[0] is high for exactly 5 of every 16 clocks; duty=0 gives a constant 0; duty=15 gives 15 high, 1 low.
- Shadowing: write ch1 static duty=3, then duty=12 mid-period -> the current period is unchanged; the next period shows 12 high. A write on the wrap cycle takes effect one period later.
- Breathing (WIDTH=4, STEP_PERIODS=2): write ch2 breathe data=14 -> level over successive steps is 14,15,14,13,...,0,1; step_tick fires every 32 clocks, coincident with period_end.
- Phase offset: ch0 breathe data=0 and ch1 breathe data=8, written in the same period -> ch1 leads ch0 by 8 steps; both remain exact triangles.
- Modes and range: write mode on -> constant 1; write mode off -> constant 0, with the change at the next wrap; wr_ch = NUM_CH -> no channel changes.
- Reset: assert RESET_N=0 mid-period with breathing active -> the next cycle has all outputs 0 and all state cleared; after release, outputs stay 0 until new writes commit.
